alpharetz_uart_rx: RTL

//  UART receiver; deserialises frames from the external uart_rx pin and hands bytes to the CPU.

---
 rtl/alpharetz_uart_rx_if.sv | 35 +++
 rtl/alpharetz_uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alpharetz_uart_rx_if.sv
// CPU-facing bundle of the UART receiver: serial pin in, byte/flags/handshake out.
interface alpharetz_uart_rx_if #(
  parameter int UART_DATA_WIDTH = 8
);
  logic                       uart_rx;
  logic                       rx_ack;
  logic [UART_DATA_WIDTH-1:0] rx_data;
  logic                       rx_valid;
  logic                       parity_err;
  logic                       frame_err;
  logic                       overrun;
  logic                       busy;

  modport slave (
    input  uart_rx,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output uart_rx,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/alpharetz_uart_rx.sv
// UART receiver: start, LSB-first data, even parity, stop; mid-bit sampling on
// enable-qualified cycles, single-entry output holding register with ack/overrun.
module alpharetz_uart_rx #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int UART_CLK_RATIO  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sync_rst,
  input  logic                  sys_clk_en,
  alpharetz_uart_rx_if.slave    bus
);

  localparam int W      = UART_DATA_WIDTH;
  localparam int R      = UART_CLK_RATIO;
  localparam int H      = R / 2;
  localparam int BAUD_W = $clog2(R);
  localparam int BIT_W  = $clog2(W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(R - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(H - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic                rx_sync_p0, rx_sync_p1;
  logic [BAUD_W-1:0]   baud_cnt, baud_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_nx;
  logic                armed;
  logic                smp_data, smp_par, smp_stop;
  logic [W-1:0]        shift_data;
  logic                par_err;
  logic [W-1:0]        data_q;
  logic                valid_q, perr_q, ferr_q, ovr_q;
  logic                ack;

  function automatic logic parity_mismatch(input logic [W-1:0] d, input logic p);
    return p ^ (^d);
  endfunction

  // Stage p0/p1: two-flop synchroniser, runs every clock regardless of enable
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.uart_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // Control state; armed blocks re-triggering on a line held low after a stop sample
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      if (sys_clk_en)
        armed <= smp_stop ? 1'b0 : (armed | rx_sync_p1);
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    smp_data = 1'b0;
    smp_par  = 1'b0;
    smp_stop = 1'b0;
    if (sys_clk_en) begin
      case (state)
        IDLE: begin
          if (!rx_sync_p1 && armed) begin
            state_nx = START;
            baud_nx  = '0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_nx  = '0;
            bit_nx   = '0;
            state_nx = rx_sync_p1 ? IDLE : DATA;
          end else begin
            baud_nx = baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_nx  = '0;
            smp_data = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_nx   = '0;
              state_nx = PARITY;
            end else begin
              bit_nx = bit_cnt + 1'b1;
            end
          end else begin
            baud_nx = baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_nx  = '0;
            smp_par  = 1'b1;
            state_nx = STOP;
          end else begin
            baud_nx = baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_nx  = '0;
            smp_stop = 1'b1;
            state_nx = IDLE;
          end else begin
            baud_nx = baud_cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          baud_nx  = '0;
          bit_nx   = '0;
        end
      endcase
    end
  end

  // Stage p2: mid-bit samples into the assembly register
  always_ff @(posedge sys_clk) begin
    if (smp_data)
      shift_data[bit_cnt] <= rx_sync_p1;
    if (smp_par)
      par_err <= parity_mismatch(shift_data, rx_sync_p1);
  end

  assign ack = bus.rx_ack && valid_q;

  // Delivery: a frame landing on a still-valid, unacknowledged word flags overrun
  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (smp_stop) begin
      data_q  <= shift_data;
      perr_q  <= par_err;
      ferr_q  <= ~rx_sync_p1;
      valid_q <= 1'b1;
      ovr_q   <= valid_q && !bus.rx_ack;
    end else if (ack) begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state != IDLE);

endmodule
